// File: rtl/ram_blk_pkg.sv
// Package: ram_blk_pkg
// Purpose: shared definitions for the RAM block engine: command op encodings,
//          FSM state type and default RAM/accumulator widths.
// Ports:   none (package).
// Config:  RAM_BLK_INCFILL_EN enables OP_FILL_INC in the engine; the encoding is
//          always defined here.
package ram_blk_pkg;

    localparam int unsigned AW_DEF = 12;
    localparam int unsigned DW_DEF = 8;
    localparam int unsigned SW_DEF = 16;

    localparam logic [1:0] OP_FILL     = 2'b00;
    localparam logic [1:0] OP_COPY     = 2'b01;
    localparam logic [1:0] OP_SUM      = 2'b10;
    localparam logic [1:0] OP_FILL_INC = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StCpRd,
        StCpWr,
        StSum,
        StDone
    } state_t;

endpackage

// File: rtl/ram_blk_ctr.sv
// Module: ram_blk_ctr
// Purpose: loadable AW-bit wrapping address counter with a remaining-count
//          register. last is high while the current address is the final one.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        load start address and length (length = count minus 1)
//   step        advance to the next address (wraps modulo 2**AW)
//   start, len  load values
//   addr        current address
//   addr_nxt    address after a step
//   last        remaining count is zero
// Config:  none.
module ram_blk_ctr
    import ram_blk_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] start,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] addr_nxt,
    output logic          last
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] rem_q;

    assign addr_nxt = addr_q + AW'(1);
    assign addr     = addr_q;
    assign last     = (rem_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (load) begin
            addr_q <= start;
            rem_q  <= len;
        end else if (step) begin
            addr_q <= addr_nxt;
            rem_q  <= rem_q - AW'(1);
        end
    end

endmodule

// File: rtl/ram_blk_engine.sv
// Module: ram_blk_engine
// Purpose: block-command initiator for a single-port RAM with synchronous write
//          and asynchronous read. Runs FILL, COPY and SUM one command at a time.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only when idle)
//   cmd_op/src/dst/len/data    command fields, latched at accept
//   busy, done, err, sum       status; done is a one-cycle pulse
//   ram_addr/din/we            registered RAM drive; ram_dout is sampled
// Config:  define RAM_BLK_INCFILL_EN to make op 11 an incrementing fill;
//          otherwise op 11 is rejected with err.
module ram_blk_engine
    import ram_blk_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [SW-1:0] sum,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    state_t        state_q, state_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_we_q, ram_we_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          err_q, err_d;
`ifdef RAM_BLK_INCFILL_EN
    logic          inc_q, inc_d;
`endif

    logic          accept;
    logic          src_step, dst_step;
    logic [AW-1:0] src_addr, src_nxt, dst_addr, dst_nxt;
    logic          src_last, dst_last;

    assign accept = cmd_valid && (state_q == StIdle);

    ram_blk_ctr #(.AW(AW)) u_src_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (src_step),
        .start    (cmd_src),
        .len      (cmd_len),
        .addr     (src_addr),
        .addr_nxt (src_nxt),
        .last     (src_last)
    );

    ram_blk_ctr #(.AW(AW)) u_dst_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step     (dst_step),
        .start    (cmd_dst),
        .len      (cmd_len),
        .addr     (dst_addr),
        .addr_nxt (dst_nxt),
        .last     (dst_last)
    );

    // RAM pins are registered, so each state computes the access for the next cycle.
    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        sum_d      = sum_q;
        err_d      = err_q;
        src_step   = 1'b0;
        dst_step   = 1'b0;
`ifdef RAM_BLK_INCFILL_EN
        inc_d      = inc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    err_d = 1'b0;
                    sum_d = '0;
                    case (cmd_op)
                        OP_FILL: begin
                            state_d    = StFill;
                            ram_addr_d = cmd_dst;
                            ram_din_d  = cmd_data;
                            ram_we_d   = 1'b1;
`ifdef RAM_BLK_INCFILL_EN
                            inc_d      = 1'b0;
`endif
                        end
`ifdef RAM_BLK_INCFILL_EN
                        OP_FILL_INC: begin
                            state_d    = StFill;
                            ram_addr_d = cmd_dst;
                            ram_din_d  = cmd_data;
                            ram_we_d   = 1'b1;
                            inc_d      = 1'b1;
                        end
`endif
                        OP_COPY: begin
                            state_d    = StCpRd;
                            ram_addr_d = cmd_src;
                        end
                        OP_SUM: begin
                            state_d    = StSum;
                            ram_addr_d = cmd_src;
                        end
                        default: begin
                            // Rejected op: no RAM access and the previous sum survives.
                            state_d = StDone;
                            err_d   = 1'b1;
                            sum_d   = sum_q;
                        end
                    endcase
                end
            end
            StFill: begin
                if (dst_last) begin
                    state_d = StDone;
                end else begin
                    dst_step   = 1'b1;
                    ram_addr_d = dst_nxt;
                    ram_we_d   = 1'b1;
`ifdef RAM_BLK_INCFILL_EN
                    if (inc_q) begin
                        ram_din_d = ram_din_q + DW'(1);
                    end
`endif
                end
            end
            StCpRd: begin
                // The write-data register doubles as the capture register for the byte read.
                state_d    = StCpWr;
                ram_addr_d = dst_addr;
                ram_din_d  = ram_dout;
                ram_we_d   = 1'b1;
                src_step   = 1'b1;
            end
            StCpWr: begin
                if (dst_last) begin
                    state_d = StDone;
                end else begin
                    state_d    = StCpRd;
                    ram_addr_d = src_addr;
                    dst_step   = 1'b1;
                end
            end
            StSum: begin
                sum_d = sum_q + SW'(ram_dout);
                if (src_last) begin
                    state_d = StDone;
                end else begin
                    src_step   = 1'b1;
                    ram_addr_d = src_nxt;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            sum_q      <= '0;
            err_q      <= 1'b0;
`ifdef RAM_BLK_INCFILL_EN
            inc_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            sum_q      <= sum_d;
            err_q      <= err_d;
`ifdef RAM_BLK_INCFILL_EN
            inc_q      <= inc_d;
`endif
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q == StFill) || (state_q == StCpRd) ||
                       (state_q == StCpWr) || (state_q == StSum);
    assign done      = (state_q == StDone);
    assign err       = err_q;
    assign sum       = sum_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;

endmodule
